// File: rtl/vdc_pipe_mul.sv
// ---------------------------------------------------------------------------
// vdc_pipe_mul : three-stage pipelined Vedic (Urdhva-Tiryagbhyam) multiplier
//
// Purpose
//   Multiplies two WIDTH-bit operands, signed or unsigned per operation, and
//   returns a 2*WIDTH-bit product with an opaque tag. The product is built
//   from four half-width Vedic products which are themselves decomposed
//   recursively down to 2x2 cells.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset (clears valids and outputs)
//   in_valid   operands/mode/tag are valid
//   in_ready   pipeline can accept an operation this cycle
//   in_a/in_b  WIDTH-bit operands
//   in_signed  1 = two's-complement operands, 0 = unsigned
//   in_tag     TAG_W-bit tag, returned unchanged with the result
//   out_valid  out_prod/out_tag hold a result
//   out_ready  downstream takes the result this cycle
//   out_prod   2*WIDTH-bit product
//   out_tag    tag of the operation in out_prod
//
// Pipeline
//   stage 0 : sign handling, operands reduced to magnitudes
//   stage 1 : four half-width partial products
//   stage 2 : partial products combined, sign re-applied, result registered
//   The whole pipeline advances together (adv = !out_valid || out_ready), so
//   a stall freezes every stage, bubbles included.
// ---------------------------------------------------------------------------

// Recursive N x N Vedic multiplier. N must be a power of two >= 2.
module VdcVedicCore #(
  parameter int N = 2
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  generate
    if (N == 2) begin : g_cell
      // 2x2 Urdhva cell: vertical, crosswise, vertical with a carry chain
      logic w_t;
      logic w_u;
      logic w_c1;
      logic w_hh;

      assign w_t  = i_a[1] & i_b[0];
      assign w_u  = i_a[0] & i_b[1];
      assign w_c1 = w_t & w_u;
      assign w_hh = i_a[1] & i_b[1];

      assign o_p[0] = i_a[0] & i_b[0];
      assign o_p[1] = w_t ^ w_u;
      assign o_p[2] = w_hh ^ w_c1;
      assign o_p[3] = w_hh & w_c1;
    end else begin : g_rec
      localparam int H = N / 2;

      logic [N-1:0] w_ll;
      logic [N-1:0] w_lh;
      logic [N-1:0] w_hl;
      logic [N-1:0] w_hh;
      logic [N:0]   w_cross;

      VdcVedicCore #(.N(H)) u_ll (.i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_p(w_ll));
      VdcVedicCore #(.N(H)) u_lh (.i_a(i_a[H-1:0]), .i_b(i_b[N-1:H]), .o_p(w_lh));
      VdcVedicCore #(.N(H)) u_hl (.i_a(i_a[N-1:H]), .i_b(i_b[H-1:0]), .o_p(w_hl));
      VdcVedicCore #(.N(H)) u_hh (.i_a(i_a[N-1:H]), .i_b(i_b[N-1:H]), .o_p(w_hh));

      // The crosswise sum needs one extra bit; dropping its carry loses
      // 2^(N+H) for large operands.
      assign w_cross = {1'b0, w_lh} + {1'b0, w_hl};

      assign o_p = {w_hh, {N{1'b0}}}
                 + {{(H-1){1'b0}}, w_cross, {H{1'b0}}}
                 + {{N{1'b0}}, w_ll};
    end
  endgenerate

endmodule

module vdc_pipe_mul #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int H = WIDTH / 2;

  logic               w_adv;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic               w_neg;

  logic               r_s0Valid;
  logic [WIDTH-1:0]   r_s0A;
  logic [WIDTH-1:0]   r_s0B;
  logic               r_s0Neg;
  logic [TAG_W-1:0]   r_s0Tag;

  logic [WIDTH-1:0]   w_ppLl;
  logic [WIDTH-1:0]   w_ppLh;
  logic [WIDTH-1:0]   w_ppHl;
  logic [WIDTH-1:0]   w_ppHh;

  logic               r_s1Valid;
  logic [WIDTH-1:0]   r_s1Ll;
  logic [WIDTH-1:0]   r_s1Lh;
  logic [WIDTH-1:0]   r_s1Hl;
  logic [WIDTH-1:0]   r_s1Hh;
  logic               r_s1Neg;
  logic [TAG_W-1:0]   r_s1Tag;

  logic [WIDTH:0]     w_cross;
  logic [2*WIDTH-1:0] w_mag;
  logic [2*WIDTH-1:0] w_prod;

  logic               r_outValid;
  logic [2*WIDTH-1:0] r_outProd;
  logic [TAG_W-1:0]   r_outTag;

  // One advance signal for the whole pipe: move whenever the output slot is
  // empty or is being drained this cycle.
  assign w_adv     = !r_outValid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_outValid;
  assign out_prod  = r_outProd;
  assign out_tag   = r_outTag;

  // Signed operands are reduced to magnitudes so the core stays unsigned.
  // Negating the most negative value wraps to 2^(WIDTH-1), which is exactly
  // its magnitude when read as unsigned.
  always_comb begin
    w_magA = in_a;
    w_magB = in_b;
    w_neg  = 1'b0;
    if (in_signed) begin
      w_neg = in_a[WIDTH-1] ^ in_b[WIDTH-1];
      if (in_a[WIDTH-1]) w_magA = -in_a;
      if (in_b[WIDTH-1]) w_magB = -in_b;
    end
  end

  // Stage 0: input register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0Valid <= 1'b0;
      r_s0A     <= '0;
      r_s0B     <= '0;
      r_s0Neg   <= 1'b0;
      r_s0Tag   <= '0;
    end else if (w_adv) begin
      r_s0Valid <= in_valid;
      r_s0A     <= w_magA;
      r_s0B     <= w_magB;
      r_s0Neg   <= w_neg;
      r_s0Tag   <= in_tag;
    end
  end

  VdcVedicCore #(.N(H)) u_ppLl (.i_a(r_s0A[H-1:0]),     .i_b(r_s0B[H-1:0]),     .o_p(w_ppLl));
  VdcVedicCore #(.N(H)) u_ppLh (.i_a(r_s0A[H-1:0]),     .i_b(r_s0B[WIDTH-1:H]), .o_p(w_ppLh));
  VdcVedicCore #(.N(H)) u_ppHl (.i_a(r_s0A[WIDTH-1:H]), .i_b(r_s0B[H-1:0]),     .o_p(w_ppHl));
  VdcVedicCore #(.N(H)) u_ppHh (.i_a(r_s0A[WIDTH-1:H]), .i_b(r_s0B[WIDTH-1:H]), .o_p(w_ppHh));

  // Stage 1: register the four half-width partial products.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Ll    <= '0;
      r_s1Lh    <= '0;
      r_s1Hl    <= '0;
      r_s1Hh    <= '0;
      r_s1Neg   <= 1'b0;
      r_s1Tag   <= '0;
    end else if (w_adv) begin
      r_s1Valid <= r_s0Valid;
      r_s1Ll    <= w_ppLl;
      r_s1Lh    <= w_ppLh;
      r_s1Hl    <= w_ppHl;
      r_s1Hh    <= w_ppHh;
      r_s1Neg   <= r_s0Neg;
      r_s1Tag   <= r_s0Tag;
    end
  end

  // Combine: cross terms are summed with their carry kept, then the sign is
  // re-applied. A zero magnitude negates to zero, so there is no -0.
  assign w_cross = {1'b0, r_s1Lh} + {1'b0, r_s1Hl};
  assign w_mag   = {r_s1Hh, {WIDTH{1'b0}}}
                 + {{(H-1){1'b0}}, w_cross, {H{1'b0}}}
                 + {{WIDTH{1'b0}}, r_s1Ll};
  assign w_prod  = r_s1Neg ? -w_mag : w_mag;

  // Stage 2: output register. Product and tag only change when a real result
  // arrives, so a bubble leaves the last result visible on out_prod/out_tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outProd  <= '0;
      r_outTag   <= '0;
    end else if (w_adv) begin
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outProd <= w_prod;
        r_outTag  <= r_s1Tag;
      end
    end
  end

endmodule

// File: tb/tb_vdc_pipe_mul.sv
// ---------------------------------------------------------------------------
// tb_vdc_pipe_mul : self-checking bench for vdc_pipe_mul (WIDTH=16, TAG_W=4)
//
// A reference queue holds the expected product/tag of every accepted
// operation, computed with plain signed/unsigned multiplication. A monitor on
// the falling edge checks each consumed result against the queue, the
// in_ready relation, and output stability during stalls. Directed tests add
// literal expectations for corner products and latency.
// ---------------------------------------------------------------------------
module tb_vdc_pipe_mul;

  localparam int W  = 16;
  localparam int TW = 4;

  typedef struct {
    logic [2*W-1:0] prod;
    logic [TW-1:0]  tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            in_signed;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_prod;
  logic [TW-1:0]   out_tag;

  int nChecks = 0;
  int nFails  = 0;
  int cycle   = 0;

  exp_t         expQ[$];
  logic [TW-1:0] popTags[$];
  int           popCycles[$];

  logic           prevHold = 1'b0;
  logic [2*W-1:0] holdProd;
  logic [TW-1:0]  holdTag;
  logic           rndDone;

  vdc_pipe_mul #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // Reference product straight from the arithmetic definition.
  function automatic logic [2*W-1:0] refMul(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic [2*W-1:0] ua;
    logic [2*W-1:0] ub;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    return ua * ub;
  endfunction

  task automatic expectEq(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  // Monitor: compares every consumed result with the reference queue and
  // records accepted operations.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expQ.delete();
      prevHold = 1'b0;
    end else begin
      expectEq("in_ready relation", in_ready, !out_valid || out_ready);
      if (prevHold) begin
        expectEq("stall out_valid", out_valid, 1);
        expectEq("stall out_prod", out_prod, holdProd);
        expectEq("stall out_tag", out_tag, holdTag);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          expectEq("unexpected result", out_valid, 0);
        end else begin
          e = expQ.pop_front();
          expectEq("model prod", out_prod, e.prod);
          expectEq("model tag", out_tag, e.tag);
          popTags.push_back(out_tag);
          popCycles.push_back(cycle);
        end
      end
      if (in_valid && in_ready) begin
        e.prod = refMul(in_a, in_b, in_signed);
        e.tag  = in_tag;
        expQ.push_back(e);
      end
      prevHold = out_valid && !out_ready;
      holdProd = out_prod;
      holdTag  = out_tag;
    end
    cycle++;
  end

  // Presents one operation and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input logic [TW-1:0] tag);
    bit done = 0;
    bit acc;
    int n = 0;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = tag;
    in_valid  = 1'b1;
    while (!done) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (acc) done = 1;
      else if (n >= 200) begin
        expectEq("accept timeout", 0, 1);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Waits for the result of the just-accepted operation (out_ready=1) and
  // checks it against literal values, including the 3-cycle latency.
  task automatic checkOutput(input logic [2*W-1:0] expProd, input logic [TW-1:0] expTag,
                             input string name);
    int lat = 0;
    bit seen = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
    end
    if (!seen) expectEq({name, " timeout"}, 0, 1);
    else begin
      expectEq({name, " prod"}, out_prod, expProd);
      expectEq({name, " tag"}, out_tag, expTag);
      expectEq({name, " latency"}, lat, 3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxCycles);
    int n = 0;
    while ((expQ.size() != 0 || out_valid) && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  initial begin
    int base;
    int okNoOut;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2*W-1:0] cornerVals [4];

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_tag = '0; out_ready = 1'b1; rndDone = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    expectEq("reset out_valid", out_valid, 0);
    expectEq("reset out_prod", out_prod, 0);
    expectEq("reset out_tag", out_tag, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    expectEq("in_ready after reset", in_ready, 1);
    @(posedge clk); #1;

    // Directed corner products
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 4'h5);
    checkOutput(32'hFFFE0001, 4'h5, "u ffff*ffff");
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 4'h1);
    checkOutput(32'h00000001, 4'h1, "s ffff*ffff");
    applyStimulus(16'h8000, 16'h8000, 1'b1, 4'h2);
    checkOutput(32'h40000000, 4'h2, "s 8000*8000");
    applyStimulus(16'h8000, 16'h0001, 1'b1, 4'h3);
    checkOutput(32'hFFFF8000, 4'h3, "s 8000*0001");
    applyStimulus(16'h0000, 16'h8000, 1'b1, 4'h4);
    checkOutput(32'h00000000, 4'h4, "s 0000*8000");
    applyStimulus(16'h7FFF, 16'h8000, 1'b1, 4'h6);
    checkOutput(32'hC0008000, 4'h6, "s 7fff*8000");
    applyStimulus(16'h8000, 16'h0001, 1'b0, 4'h7);
    checkOutput(32'h00008000, 4'h7, "u 8000*0001");

    // Back-to-back stream of 8, tags 0..7
    drain(20);
    base = popTags.size();
    for (int i = 0; i < 8; i++)
      applyStimulus(W'(16'h1357 * (i + 3)), W'(16'hF00D - 16'h0321 * i), i[0], TW'(i));
    drain(20);
    expectEq("stream count", popTags.size() - base, 8);
    if (popTags.size() - base == 8) begin
      for (int i = 0; i < 8; i++) expectEq("stream tag order", popTags[base + i], i);
      expectEq("stream contiguous", popCycles[base + 7] - popCycles[base], 7);
    end

    // Backpressure: out_ready low for 3 cycles mid-stream
    base = popTags.size();
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(W'(16'hA5A5 ^ (i * 16'h1111)), W'(16'h8001 + i * 16'h0F0F), ~i[0], TW'(8 + i));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        expectEq("stall out_valid held", out_valid, 1);
        expectEq("stall in_ready low", in_ready, 0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain(30);
    expectEq("backpressure count", popTags.size() - base, 8);
    if (popTags.size() - base == 8)
      for (int i = 0; i < 8; i++) expectEq("backpressure tag order", popTags[base + i], 8 + i);

    // Reset mid-flight: two ops discarded
    base = popTags.size();
    applyStimulus(16'h1234, 16'h5678, 1'b0, 4'hA);
    applyStimulus(16'h4321, 16'h8765, 1'b1, 4'hB);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    okNoOut = 1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) okNoOut = 0;
    end
    expectEq("no result after reset", okNoOut, 1);
    expectEq("no pops after reset", popTags.size() - base, 0);
    @(posedge clk); #1;
    applyStimulus(16'h0003, 16'hFFFD, 1'b1, 4'hC);
    checkOutput(32'hFFFFFFF7, 4'hC, "post-reset 3*-3");

    // Random regression with random out_ready
    cornerVals[0] = 32'h0000; cornerVals[1] = 32'h8000;
    cornerVals[2] = 32'hFFFF; cornerVals[3] = 32'h7FFF;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          ra = W'($urandom);
          rb = W'($urandom);
          if ($urandom_range(0, 5) == 0) ra = cornerVals[$urandom_range(0, 3)][W-1:0];
          if ($urandom_range(0, 5) == 0) rb = cornerVals[$urandom_range(0, 3)][W-1:0];
          applyStimulus(ra, rb, 1'($urandom_range(0, 1)), TW'($urandom));
          if ($urandom_range(0, 3) == 0) @(posedge clk);
          #1;
        end
        rndDone = 1'b1;
      end
      begin
        while (!rndDone) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain(100);
    expectEq("queue drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL global timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
